// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for the compare/retire stage.
//   cond_t      : branch condition codes evaluated against the comparator flags
//   buf_state_t : occupancy of the two-entry in-order retire buffer
//   FLAG_*      : bit positions inside the 4-bit {Z,EQ,GT,LT} flag vector
// -----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_ALWAYS = 3'b001,
        COND_EQ     = 3'b010,
        COND_NE     = 3'b011,
        COND_GT     = 3'b100,
        COND_LT     = 3'b101,
        COND_GE     = 3'b110,
        COND_LE     = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam int FLAG_Z  = 3;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational branch-condition evaluator.
//   cond  (in, 3) : branch condition code (cond_t encoding)
//   flags (in, 4) : {Z,EQ,GT,LT} flags of the entry being accepted
//   take  (out,1) : 1 when the branch is taken
// -----------------------------------------------------------------------------
module cond_eval
    import cmp_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond_t'(cond))
            COND_NEVER:  take = 1'b0;
            COND_ALWAYS: take = 1'b1;
            COND_EQ:     take = flags[FLAG_EQ];
            COND_NE:     take = !flags[FLAG_EQ];
            COND_GT:     take = flags[FLAG_GT];
            COND_LT:     take = flags[FLAG_LT];
            COND_GE:     take = flags[FLAG_GT] | flags[FLAG_EQ];
            COND_LE:     take = flags[FLAG_LT] | flags[FLAG_EQ];
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_retire_stage.sv
// -----------------------------------------------------------------------------
// cmp_retire_stage
// Retire stage for compare/logic results: a two-entry in-order skid buffer that
// captures the logic result, per-entry {Z,EQ,GT,LT} flags and the branch-taken
// decision at accept time, and updates the architectural flag register and the
// retire counter whenever the head entry leaves.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : upstream handshake (in_ready is a flop)
//   in_opcode, in_y            : opcode and logic result of the offered entry
//   in_eq, in_gt, in_lt        : comparator flags of the offered entry
//   in_cond                    : branch condition code of the offered entry
//   out_valid/out_ready        : downstream handshake
//   out_opcode, out_y          : head entry opcode and result
//   out_flags, out_take        : head entry {Z,EQ,GT,LT} and branch decision
//   flags_q                    : architectural flags, loaded on every emit
//   flag_err                   : sticky, set by an accepted non-one-hot flag set
//   ret_cnt                    : number of retired entries, wraps at 256
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and once out_valid is high the out_*
// fields hold their value until the transfer completes. No combinational path
// runs from any in_* port to any out_* port.
// -----------------------------------------------------------------------------
module cmp_retire_stage
    import cmp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_opcode,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_eq,
    input  logic              in_gt,
    input  logic              in_lt,
    input  logic [2:0]        in_cond,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_opcode,
    output logic [DATA_W-1:0] out_y,
    output logic [3:0]        out_flags,
    output logic              out_take,
    output logic [3:0]        flags_q,
    output logic              flag_err,
    output logic [7:0]        ret_cnt
);

    // Buffer occupancy; kept as a named signal so checkers can bind to it.
    buf_state_t state;

    // Second (tail) slot, only meaningful in BUF_FULL. The head slot is the
    // out_* register set itself.
    logic [7:0]        slot_opcode;
    logic [DATA_W-1:0] slot_y;
    logic [3:0]        slot_flags;
    logic              slot_take;

    logic       accept;
    logic       emit;
    logic [3:0] new_flags;
    logic       new_take;
    logic       flags_legal;

    assign accept      = in_valid && in_ready;
    assign emit        = out_valid && out_ready;
    assign out_valid   = (state != BUF_EMPTY);
    assign flags_legal = $onehot({in_eq, in_gt, in_lt});

    always_comb begin
        new_flags          = '0;
        new_flags[FLAG_Z]  = (in_y == '0);
        new_flags[FLAG_EQ] = in_eq;
        new_flags[FLAG_GT] = in_gt;
        new_flags[FLAG_LT] = in_lt;
    end

    cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (new_flags),
        .take  (new_take)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BUF_EMPTY;
            in_ready    <= 1'b1;
            out_opcode  <= '0;
            out_y       <= '0;
            out_flags   <= '0;
            out_take    <= 1'b0;
            slot_opcode <= '0;
            slot_y      <= '0;
            slot_flags  <= '0;
            slot_take   <= 1'b0;
            flags_q     <= '0;
            flag_err    <= 1'b0;
            ret_cnt     <= '0;
        end else begin
            // Retire bookkeeping always uses the head as it was before this edge.
            if (emit) begin
                flags_q <= out_flags;
                ret_cnt <= ret_cnt + 8'd1;
            end
            // The offending entry is still buffered as-is; only the error sticks.
            if (accept && !flags_legal) begin
                flag_err <= 1'b1;
            end

            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        out_opcode <= in_opcode;
                        out_y      <= in_y;
                        out_flags  <= new_flags;
                        out_take   <= new_take;
                        state      <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && emit) begin
                        // Old head leaves, new entry becomes head directly.
                        out_opcode <= in_opcode;
                        out_y      <= in_y;
                        out_flags  <= new_flags;
                        out_take   <= new_take;
                    end else if (accept) begin
                        slot_opcode <= in_opcode;
                        slot_y      <= in_y;
                        slot_flags  <= new_flags;
                        slot_take   <= new_take;
                        state       <= BUF_FULL;
                        in_ready    <= 1'b0;
                    end else if (emit) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so only an emit can move the state.
                    if (emit) begin
                        out_opcode <= slot_opcode;
                        out_y      <= slot_y;
                        out_flags  <= slot_flags;
                        out_take   <= slot_take;
                        state      <= BUF_ONE;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state    <= BUF_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_retire_stage.sv
// -----------------------------------------------------------------------------
// tb_cmp_retire_stage
// Directed scenarios plus randomized traffic against a queue-based model of a
// two-deep in-order buffer. Inputs change on the falling edge; outputs are
// compared on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_cmp_retire_stage;

    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [DATA_W-1:0] in_y;
    logic              in_eq, in_gt, in_lt;
    logic [2:0]        in_cond;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_opcode;
    logic [DATA_W-1:0] out_y;
    logic [3:0]        out_flags;
    logic              out_take;
    logic [3:0]        flags_q;
    logic              flag_err;
    logic [7:0]        ret_cnt;

    cmp_retire_stage #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_y       (in_y),
        .in_eq      (in_eq),
        .in_gt      (in_gt),
        .in_lt      (in_lt),
        .in_cond    (in_cond),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .out_take   (out_take),
        .flags_q    (flags_q),
        .flag_err   (flag_err),
        .ret_cnt    (ret_cnt)
    );

    // ---------------- scoreboard / model ----------------
    // Entry packing: {opcode[20:13], y[12:5], flags[4:1], take[0]}
    localparam int W = 21;
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_flags;
    int           m_retired;
    bit           m_err;
    bit           m_valid;     // model is meaningful only after the first reset
    bit           m_zero_chk;  // next sample directly follows a reset

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_take(input int cond, input bit eq, input bit gt, input bit lt);
        case (cond)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return eq;
            3:       return !eq;
            4:       return gt;
            5:       return lt;
            6:       return gt || eq;
            default: return lt || eq;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rstn, input bit v, input logic [7:0] op, input logic [7:0] y,
                        input bit eq, input bit gt, input bit lt, input logic [2:0] cond,
                        input bit ordy);
        logic [W-1:0] head;
        logic [W-1:0] ent;
        bit           acc, em;
        logic [3:0]   fl;
        @(negedge clk);
        rst_n = rstn; in_valid = v; in_opcode = op; in_y = y;
        in_eq = eq; in_gt = gt; in_lt = lt; in_cond = cond; out_ready = ordy;
        #1;
        if (m_valid) begin
            check("in_ready", in_ready, exp_q.size() < 2);
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("out_opcode", out_opcode, head[20:13]);
                check("out_y", out_y, head[12:5]);
                check("out_flags", out_flags, head[4:1]);
                check("out_take", out_take, head[0]);
            end
            if (m_zero_chk) begin
                check("rst_out_y", out_y, 0);
                check("rst_out_opcode", out_opcode, 0);
                check("rst_out_flags", out_flags, 0);
                check("rst_out_take", out_take, 0);
            end
            check("flags_q", flags_q, m_flags);
            check("ret_cnt", ret_cnt, m_retired % 256);
            check("flag_err", flag_err, m_err);
        end
        m_zero_chk = 0;
        if (!rstn) begin
            exp_q.delete();
            m_flags = 0; m_retired = 0; m_err = 0;
            m_valid = 1; m_zero_chk = 1;
        end else if (m_valid) begin
            acc = v && (exp_q.size() < 2);
            em  = ordy && (exp_q.size() > 0);
            if (em) begin
                head = exp_q.pop_front();
                m_flags = head[4:1];
                m_retired++;
            end
            if (acc) begin
                fl = {y == 8'd0, eq, gt, lt};
                ent = {op, y, fl, ref_take(int'(cond), eq, gt, lt)};
                exp_q.push_back(ent);
                if ((int'(eq) + int'(gt) + int'(lt)) != 1) m_err = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit ordy);
        step(1, 0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic rnd_step(input int ready_pct, input int valid_pct);
        logic [7:0] a, b, y;
        bit eq, gt, lt;
        a = 8'($urandom_range(0, 15));
        b = 8'($urandom_range(0, 15));
        eq = (a == b); gt = (a > b); lt = (a < b);
        if ($urandom_range(0, 19) == 0) begin
            eq = 1'($urandom); gt = 1'($urandom); lt = 1'($urandom);
        end
        y = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        step(1, $urandom_range(0, 99) < valid_pct, 8'($urandom), y, eq, gt, lt,
             3'($urandom), $urandom_range(0, 99) < ready_pct);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] conds [4];
        rst_n = 0; in_valid = 0; in_opcode = 0; in_y = 0;
        in_eq = 0; in_gt = 0; in_lt = 0; in_cond = 0; out_ready = 0;
        m_valid = 0; m_zero_chk = 0; m_flags = 0; m_retired = 0; m_err = 0;

        // Scenario 1: zero result, EQ, cond EQ
        do_reset();
        do_reset();
        step(1, 1, 8'h5A, 8'h00, 1, 0, 0, 3'b010, 1);
        idle(1);
        idle(1);
        check("s1_flags_q", flags_q, 4'b1100);
        check("s1_ret_cnt", ret_cnt, 1);

        // Scenario 2: back-pressure with three offers
        step(1, 1, 8'h01, 8'h11, 0, 1, 0, 3'b001, 0);
        step(1, 1, 8'h02, 8'h22, 0, 0, 1, 3'b101, 0);
        step(1, 1, 8'h03, 8'h33, 1, 0, 0, 3'b011, 0);
        step(1, 1, 8'h03, 8'h33, 1, 0, 0, 3'b011, 1);
        step(1, 1, 8'h03, 8'h33, 1, 0, 0, 3'b011, 1);
        idle(1);
        idle(1);
        idle(1);

        // Scenario 3: GT flags under several conditions
        conds[0] = 3'b100; conds[1] = 3'b110; conds[2] = 3'b111; conds[3] = 3'b011;
        foreach (conds[i]) step(1, 1, 8'(i), 8'h40 + 8'(i), 0, 1, 0, conds[i], 1);
        idle(1);
        idle(1);

        // Scenario 4: illegal flags, then legal traffic, error must persist
        step(1, 1, 8'hEE, 8'h07, 1, 1, 0, 3'b110, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 8'(i), 8'(i + 1), 0, 0, 1, 3'b101, 1);
        idle(1);
        check("s4_err_sticky", flag_err, 1);
        do_reset();
        idle(0);

        // Scenario 5: 256 back-to-back transfers
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 8'(i), 8'(i), 0, 0, 1, 3'b001, 1);
            if (i > 0) check("s5_out_valid", out_valid, 1);
            check("s5_in_ready", in_ready, 1);
        end
        idle(1);
        idle(1);
        check("s5_ret_wrap", ret_cnt, 0);

        // Scenario 6: reset while FULL
        step(1, 1, 8'hA1, 8'h91, 0, 1, 0, 3'b001, 0);
        step(1, 1, 8'hA2, 8'h92, 0, 1, 0, 3'b001, 0);
        idle(0);
        check("s6_full_in_ready", in_ready, 0);
        do_reset();
        idle(1);
        check("s6_out_valid", out_valid, 0);
        check("s6_in_ready", in_ready, 1);
        idle(1);
        idle(1);

        // Randomized traffic with varying back-pressure
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 250) do_reset();
            else rnd_step((i < 500) ? 50 : (i < 1000) ? 90 : 20, 70);
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
